// File: rtl/udp_tx_arbiter_if.sv
// Requester-side and PHY-side stream signals of the UDP tx arbiter.
// The arbiter takes the slave view; requesters and PHY together take the master view.
interface udp_tx_arbiter_if #(
  parameter int NUM_PORTS = 4
);
  logic [NUM_PORTS-1:0]   i_req_valid;
  logic [NUM_PORTS*8-1:0] i_req_data;
  logic [NUM_PORTS-1:0]   i_req_last;
  logic [NUM_PORTS-1:0]   i_req_user;
  logic [NUM_PORTS-1:0]   o_req_ready;
  logic                   o_tx_valid;
  logic [7:0]             o_tx_data;
  logic                   o_tx_last;
  logic                   o_tx_user;
  logic                   i_tx_ready;
  logic [NUM_PORTS-1:0]   o_grant;
  logic                   o_busy;

  modport slave (
    input  i_req_valid, i_req_data, i_req_last, i_req_user, i_tx_ready,
    output o_req_ready, o_tx_valid, o_tx_data, o_tx_last, o_tx_user, o_grant, o_busy
  );

  modport master (
    output i_req_valid, i_req_data, i_req_last, i_req_user, i_tx_ready,
    input  o_req_ready, o_tx_valid, o_tx_data, o_tx_last, o_tx_user, o_grant, o_busy
  );
endinterface

// File: rtl/udp_tx_arbiter.sv
// Packet-level round-robin arbiter feeding one byte-wide PHY tx stream.
// state   | meaning
// IDLE    | no owner; pick next requester from rr pointer (1-cycle arbitration)
// XFER    | granted requester streams straight through until an accepted tlast
// GAP     | forced idle cycles after a packet before arbitrating again
module udp_tx_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int GAP_CYCLES = 0
) (
  input  logic            i_clock,
  input  logic            i_reset,
  udp_tx_arbiter_if.slave io_bus
);
  localparam int         IW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [7:0] GAP_W = 8'(GAP_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [NUM_PORTS-1:0] r_grant;
  logic [IW-1:0]        r_gidx;
  logic [IW-1:0]        r_rr;
  logic [7:0]           r_gap;

  logic [IW-1:0]        w_sel;
  logic [IW-1:0]        w_rr_nxt;
  logic [NUM_PORTS-1:0] w_sel_oh;
  logic                 w_found;
  logic                 w_any;
  logic                 w_g_valid;
  logic [7:0]           w_g_data;
  logic                 w_g_last;
  logic                 w_g_user;
  logic                 w_accept;
  logic                 w_eop;

  assign w_any     = |io_bus.i_req_valid;
  assign w_g_valid = io_bus.i_req_valid[r_gidx];
  assign w_g_data  = io_bus.i_req_data[{r_gidx, 3'b000} +: 8];
  assign w_g_last  = io_bus.i_req_last[r_gidx];
  assign w_g_user  = io_bus.i_req_user[r_gidx];
  assign w_accept  = (r_state == ST_XFER) && w_g_valid && io_bus.i_tx_ready;
  assign w_eop     = w_accept && w_g_last;
  assign w_rr_nxt  = (r_gidx == IW'(NUM_PORTS - 1)) ? '0 : r_gidx + 1'b1;
  assign w_sel_oh  = {{(NUM_PORTS-1){1'b0}}, 1'b1} << w_sel;

  // First valid requester at or above the rr pointer, wrapping.
  always_comb begin : rr_scan
    int j;
    j       = 0;
    w_sel   = r_rr;
    w_found = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      j = int'(r_rr) + k;
      if (j >= NUM_PORTS) j = j - NUM_PORTS;
      if (!w_found && io_bus.i_req_valid[j]) begin
        w_found = 1'b1;
        w_sel   = IW'(j);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_any) w_state_nxt = ST_XFER;
      ST_XFER: if (w_eop) w_state_nxt = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
      ST_GAP:  if (r_gap <= 8'd1) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    io_bus.o_tx_valid  = 1'b0;
    io_bus.o_tx_data   = 8'd0;
    io_bus.o_tx_last   = 1'b0;
    io_bus.o_tx_user   = 1'b0;
    io_bus.o_req_ready = '0;
    if (r_state == ST_XFER) begin
      io_bus.o_tx_valid          = w_g_valid;
      io_bus.o_tx_data           = w_g_data;
      io_bus.o_tx_last           = w_g_last;
      io_bus.o_tx_user           = w_g_user;
      io_bus.o_req_ready[r_gidx] = io_bus.i_tx_ready;
    end
  end

  assign io_bus.o_grant = r_grant;
  assign io_bus.o_busy  = (r_state != ST_IDLE);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_gidx  <= '0;
      r_rr    <= '0;
      r_gap   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_grant <= w_sel_oh;
            r_gidx  <= w_sel;
          end
        end
        ST_XFER: begin
          if (w_eop) begin
            r_grant <= '0;
            r_rr    <= w_rr_nxt;
            r_gap   <= GAP_W;
          end
        end
        ST_GAP:  r_gap <= r_gap - 8'd1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Bench for udp_tx_arbiter: directed scenarios plus a randomized run against a packet-rule model.
`timescale 1ns/1ps
module tb_udp_tx_arbiter;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_last  = '0;
  logic [N-1:0]   req_user  = '0;
  logic [N*8-1:0] req_data  = '0;
  logic           tx_ready  = 1'b0;
  int             total = 0;
  int             bad   = 0;

  udp_tx_arbiter_if #(.NUM_PORTS(N)) if0 ();
  udp_tx_arbiter_if #(.NUM_PORTS(N)) if1 ();

  assign if0.i_req_valid = req_valid;
  assign if0.i_req_data  = req_data;
  assign if0.i_req_last  = req_last;
  assign if0.i_req_user  = req_user;
  assign if0.i_tx_ready  = tx_ready;
  assign if1.i_req_valid = req_valid;
  assign if1.i_req_data  = req_data;
  assign if1.i_req_last  = req_last;
  assign if1.i_req_user  = req_user;
  assign if1.i_tx_ready  = tx_ready;

  udp_tx_arbiter #(.NUM_PORTS(N), .GAP_CYCLES(0)) dut0 (
    .i_clock(clk), .i_reset(rst), .io_bus(if0.slave)
  );
  udp_tx_arbiter #(.NUM_PORTS(N), .GAP_CYCLES(3)) dut1 (
    .i_clock(clk), .i_reset(rst), .io_bus(if1.slave)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = '0;
    req_last  = '0;
    req_user  = '0;
    req_data  = '0;
  endtask

  task automatic set_byte(input int p, input logic [7:0] b);
    req_data[p*8 +: 8] = b;
  endtask

  task automatic do_reset();
    idle_inputs();
    tx_ready = 1'b0;
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [19:0] act0, act1;
    do_reset();
    tx_ready     = 1'b1;
    req_valid[0] = 1'b1;
    set_byte(0, 8'hA5);
    @(negedge clk);
    total++;
    if (if0.o_grant !== 4'b0000) begin
      bad++; $display("FAIL reset_pre_arb grant act=%b exp=0000", if0.o_grant);
    end
    next_cycle();
    total++;
    if ({if0.o_grant, if0.o_tx_valid, if0.o_tx_data} !== {4'b0001, 1'b1, 8'hA5}) begin
      bad++; $display("FAIL reset_granted act=%b/%b/%h exp=0001/1/a5", if0.o_grant, if0.o_tx_valid, if0.o_tx_data);
    end
    #2 rst = 1'b1;
    #1;
    act0 = {if0.o_req_ready, if0.o_tx_valid, if0.o_tx_data, if0.o_tx_last, if0.o_tx_user, if0.o_grant, if0.o_busy};
    act1 = {if1.o_req_ready, if1.o_tx_valid, if1.o_tx_data, if1.o_tx_last, if1.o_tx_user, if1.o_grant, if1.o_busy};
    total++;
    if (act0 !== 20'd0) begin
      bad++; $display("FAIL reset_async_dut0 act=%h exp=00000", act0);
    end
    total++;
    if (act1 !== 20'd0) begin
      bad++; $display("FAIL reset_async_dut1 act=%h exp=00000", act1);
    end
    idle_inputs();
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({if0.o_grant, if0.o_busy, if0.o_tx_valid} !== 6'd0) begin
        bad++; $display("FAIL reset_idle cyc=%0d grant=%b busy=%b valid=%b exp=0", i, if0.o_grant, if0.o_busy, if0.o_tx_valid);
      end
      next_cycle();
    end
  endtask

  task automatic test_single();
    logic [7:0] b;
    do_reset();
    tx_ready     = 1'b1;
    req_valid[2] = 1'b1;
    set_byte(2, 8'h11);
    @(negedge clk);
    total++;
    if (if0.o_grant !== 4'b0000 || if0.o_tx_valid !== 1'b0) begin
      bad++; $display("FAIL single_arb_latency grant=%b valid=%b exp=0000/0", if0.o_grant, if0.o_tx_valid);
    end
    next_cycle();
    for (int i = 0; i < 5; i++) begin
      b = 8'(8'h11 + i);
      set_byte(2, b);
      req_last[2] = (i == 4);
      @(negedge clk);
      total++;
      if ({if0.o_grant, if0.o_tx_valid, if0.o_tx_data, if0.o_tx_last, if0.o_req_ready} !==
          {4'b0100, 1'b1, b, (i == 4), 4'b0100}) begin
        bad++; $display("FAIL single_beat%0d act=%b/%b/%h/%b/%b exp=0100/1/%h/%b/0100", i,
                        if0.o_grant, if0.o_tx_valid, if0.o_tx_data, if0.o_tx_last, if0.o_req_ready, b, (i == 4));
      end
      next_cycle();
    end
    idle_inputs();
    @(negedge clk);
    total++;
    if (if0.o_grant !== 4'b0000 || if0.o_busy !== 1'b0) begin
      bad++; $display("FAIL single_release grant=%b busy=%b exp=0000/0", if0.o_grant, if0.o_busy);
    end
    total++;
    if (if1.o_grant !== 4'b0000 || if1.o_busy !== 1'b1) begin
      bad++; $display("FAIL single_gap_dut1 grant=%b busy=%b exp=0000/1", if1.o_grant, if1.o_busy);
    end
  endtask

  task automatic test_rr_fair();
    int         beat[N];
    int         pkt[N];
    int         exp_pkt[N];
    int         exp_port, exp_beat, got_pkts;
    logic [N-1:0] rdy, oh;
    logic [7:0] eb;
    do_reset();
    tx_ready = 1'b1;
    for (int p = 0; p < N; p++) begin beat[p] = 0; pkt[p] = 0; exp_pkt[p] = 0; end
    exp_port = 0; exp_beat = 0; got_pkts = 0;
    for (int cyc = 0; cyc < 200 && got_pkts < 12; cyc++) begin
      for (int p = 0; p < N; p++) begin
        req_valid[p] = 1'b1;
        set_byte(p, {2'(p), 3'(pkt[p]), 3'(beat[p])});
        req_last[p] = (beat[p] == 2);
      end
      @(negedge clk);
      rdy = if0.o_req_ready;
      if (if0.o_tx_valid && tx_ready) begin
        eb = {2'(exp_port), 3'(exp_pkt[exp_port]), 3'(exp_beat)};
        oh = '0;
        oh[exp_port] = 1'b1;
        total++;
        if ({if0.o_grant, if0.o_tx_data, if0.o_tx_last} !== {oh, eb, (exp_beat == 2)}) begin
          bad++; $display("FAIL rr_beat pkt=%0d act=%b/%h/%b exp=%b/%h/%b", got_pkts,
                          if0.o_grant, if0.o_tx_data, if0.o_tx_last, oh, eb, (exp_beat == 2));
        end
        exp_beat++;
        if (exp_beat == 3) begin
          exp_beat = 0;
          exp_pkt[exp_port]++;
          exp_port = (exp_port + 1) % N;
          got_pkts++;
        end
      end
      next_cycle();
      for (int p = 0; p < N; p++) begin
        if (rdy[p]) begin
          beat[p]++;
          if (beat[p] == 3) begin beat[p] = 0; pkt[p]++; end
        end
      end
    end
    total++;
    if (got_pkts != 12) begin
      bad++; $display("FAIL rr_timeout packets=%0d exp=12", got_pkts);
    end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    logic [7:0] got[$];
    int         idx;
    logic       acc;
    do_reset();
    req_valid[1] = 1'b1;
    set_byte(1, 8'hC0);
    @(negedge clk);
    next_cycle();
    idx = 0;
    for (int cyc = 0; cyc < 20 && idx < 4; cyc++) begin
      tx_ready = (cyc % 2 == 0);
      set_byte(1, 8'(8'hC0 + idx));
      req_last[1] = (idx == 3);
      @(negedge clk);
      total++;
      if (if0.o_req_ready !== {2'b00, tx_ready, 1'b0}) begin
        bad++; $display("FAIL bp_ready cyc=%0d act=%b exp=%b", cyc, if0.o_req_ready, {2'b00, tx_ready, 1'b0});
      end
      acc = if0.o_tx_valid && tx_ready;
      if (acc) got.push_back(if0.o_tx_data);
      next_cycle();
      if (acc) idx++;
    end
    total++;
    if (got.size() != 4) begin
      bad++; $display("FAIL bp_count act=%0d exp=4", got.size());
    end
    for (int i = 0; i < got.size() && i < 4; i++) begin
      total++;
      if (got[i] !== 8'(8'hC0 + i)) begin
        bad++; $display("FAIL bp_order idx=%0d act=%h exp=%h", i, got[i], 8'(8'hC0 + i));
      end
    end
    idle_inputs();
  endtask

  task automatic test_gap();
    int           b0, b1, idle_cnt, busy_cnt;
    logic         seen_last0, done, beat;
    logic [N-1:0] rdy;
    do_reset();
    tx_ready = 1'b1;
    b0 = 0; b1 = 0; idle_cnt = 0; busy_cnt = 0;
    seen_last0 = 1'b0; done = 1'b0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      req_valid[0] = (b0 < 2);
      set_byte(0, 8'(8'h40 + b0));
      req_last[0]  = (b0 == 1);
      req_valid[1] = (b1 < 2);
      set_byte(1, 8'(8'h50 + b1));
      req_last[1]  = (b1 == 1);
      @(negedge clk);
      rdy  = if1.o_req_ready;
      beat = if1.o_tx_valid && tx_ready;
      if (seen_last0) begin
        if (beat) begin
          done = 1'b1;
          total++;
          if ({if1.o_grant, if1.o_tx_data} !== {4'b0010, 8'h50}) begin
            bad++; $display("FAIL gap_next_pkt act=%b/%h exp=0010/50", if1.o_grant, if1.o_tx_data);
          end
        end else begin
          idle_cnt++;
          if (if1.o_busy) busy_cnt++;
        end
      end else if (beat && if1.o_tx_last && if1.o_grant == 4'b0001) begin
        seen_last0 = 1'b1;
      end
      next_cycle();
      if (rdy[0] && req_valid[0]) b0++;
      if (rdy[1] && req_valid[1]) b1++;
    end
    total++;
    if (!done) begin
      bad++; $display("FAIL gap_timeout seen_last0=%b exp=second packet started", seen_last0);
    end
    total++;
    if (idle_cnt != 4) begin
      bad++; $display("FAIL gap_idle_cycles act=%0d exp=4", idle_cnt);
    end
    total++;
    if (busy_cnt != 3) begin
      bad++; $display("FAIL gap_busy_cycles act=%0d exp=3", busy_cnt);
    end
    idle_inputs();
  endtask

  task automatic test_stall_user();
    int   idx, stall;
    logic stalling, acc;
    logic [7:0] b;
    do_reset();
    tx_ready     = 1'b1;
    req_valid[3] = 1'b1;
    set_byte(3, 8'h30);
    @(negedge clk);
    next_cycle();
    req_valid[0] = 1'b1;
    set_byte(0, 8'h77);
    req_last[0] = 1'b1;
    idx = 0; stall = 0;
    for (int cyc = 0; cyc < 20 && idx < 4; cyc++) begin
      stalling = (idx == 2 && stall < 2);
      if (stalling) stall++;
      req_valid[3] = !stalling;
      b = 8'(8'h30 + idx);
      set_byte(3, b);
      req_last[3] = (idx == 3);
      req_user[3] = (idx == 3);
      @(negedge clk);
      total++;
      if (if0.o_grant !== 4'b1000) begin
        bad++; $display("FAIL stall_grant cyc=%0d act=%b exp=1000", cyc, if0.o_grant);
      end
      total++;
      if (stalling) begin
        if (if0.o_tx_valid !== 1'b0 || if0.o_req_ready !== 4'b1000) begin
          bad++; $display("FAIL stall_hold valid=%b ready=%b exp=0/1000", if0.o_tx_valid, if0.o_req_ready);
        end
      end else if ({if0.o_tx_valid, if0.o_tx_data, if0.o_tx_last, if0.o_tx_user} !== {1'b1, b, (idx == 3), (idx == 3)}) begin
        bad++; $display("FAIL stall_beat%0d act=%b/%h/%b/%b exp=1/%h/%b/%b", idx,
                        if0.o_tx_valid, if0.o_tx_data, if0.o_tx_last, if0.o_tx_user, b, (idx == 3), (idx == 3));
      end
      acc = if0.o_req_ready[3] && req_valid[3];
      next_cycle();
      if (acc) idx++;
    end
    total++;
    if (idx != 4) begin
      bad++; $display("FAIL stall_timeout beats=%0d exp=4", idx);
    end
    req_valid[3] = 1'b0; req_last[3] = 1'b0; req_user[3] = 1'b0;
    @(negedge clk);
    total++;
    if (if0.o_grant !== 4'b0000) begin
      bad++; $display("FAIL stall_release act=%b exp=0000", if0.o_grant);
    end
    next_cycle();
    @(negedge clk);
    total++;
    if ({if0.o_grant, if0.o_tx_data, if0.o_tx_user} !== {4'b0001, 8'h77, 1'b0}) begin
      bad++; $display("FAIL stall_next_port act=%b/%h/%b exp=0001/77/0", if0.o_grant, if0.o_tx_data, if0.o_tx_user);
    end
    next_cycle();
    idle_inputs();
  endtask

  // Model per instance: who owns the stream (-1 none), rr start, GAP cycles left.
  task automatic test_random();
    int          m_owner[2], m_rr[2], m_gap[2], gapv[2];
    int          o, p;
    logic [19:0] act[2], expv;
    logic [N-1:0] e_ready, e_grant;
    logic [7:0]  e_data;
    logic        e_valid, e_last, e_user, e_busy;
    gapv[0] = 0; gapv[1] = 3;
    do_reset();
    for (int d = 0; d < 2; d++) begin m_owner[d] = -1; m_rr[d] = 0; m_gap[d] = 0; end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int q = 0; q < N; q++) begin
        req_valid[q] = ($urandom_range(0, 3) != 0);
        req_last[q]  = ($urandom_range(0, 3) == 0);
        req_user[q]  = 1'($urandom_range(0, 1));
      end
      req_data = $urandom();
      tx_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      act[0] = {if0.o_req_ready, if0.o_tx_valid, if0.o_tx_data, if0.o_tx_last, if0.o_tx_user, if0.o_grant, if0.o_busy};
      act[1] = {if1.o_req_ready, if1.o_tx_valid, if1.o_tx_data, if1.o_tx_last, if1.o_tx_user, if1.o_grant, if1.o_busy};
      for (int d = 0; d < 2; d++) begin
        if (rst) begin m_owner[d] = -1; m_rr[d] = 0; m_gap[d] = 0; end
        o = m_owner[d];
        e_ready = '0; e_grant = '0; e_data = 8'd0;
        e_valid = 1'b0; e_last = 1'b0; e_user = 1'b0; e_busy = 1'b0;
        if (o >= 0) begin
          e_valid    = req_valid[o];
          e_data     = req_data[o*8 +: 8];
          e_last     = req_last[o];
          e_user     = req_user[o];
          e_ready[o] = tx_ready;
          e_grant[o] = 1'b1;
          e_busy     = 1'b1;
        end else if (m_gap[d] > 0) begin
          e_busy = 1'b1;
        end
        expv = {e_ready, e_valid, e_data, e_last, e_user, e_grant, e_busy};
        total++;
        if (act[d] !== expv) begin
          bad++; $display("FAIL random dut%0d cyc=%0d act=%h exp=%h", d, cyc, act[d], expv);
        end
        if (!rst) begin
          if (o >= 0) begin
            if (req_valid[o] && tx_ready && req_last[o]) begin
              m_rr[d]    = (o + 1) % N;
              m_owner[d] = -1;
              m_gap[d]   = gapv[d];
            end
          end else if (m_gap[d] > 0) begin
            m_gap[d]--;
          end else begin
            for (int k = 0; k < N; k++) begin
              p = (m_rr[d] + k) % N;
              if (req_valid[p]) begin
                m_owner[d] = p;
                break;
              end
            end
          end
        end
      end
      next_cycle();
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr_fair();
    test_backpressure();
    test_gap();
    test_stall_user();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/udp_tx_arbiter.md
Name: udp_tx_arbiter

Overview:
Packet-level round-robin arbiter that shares the single byte-wide UDP/Ethernet transmit stream between NUM_PORTS AXI-stream style requesters. It sits directly in front of the EthernetPHY tx interface (tdata/tlast/tuser, valid/ready). Once a packet starts, the grant is held until tlast, so frames are never interleaved. A configurable idle gap is inserted between granted packets.

Parameters:
NUM_PORTS, 4, number of requesters (2..8)
GAP_CYCLES, 0, idle cycles forced after each packet's last beat before the next arbitration (0..255)

Ports:
i_clock  input  1  system clock (same domain as the EthernetPHY clock input)
i_reset  input  1  asynchronous, active-high reset
i_req_valid  input  NUM_PORTS  per-requester beat valid
i_req_data  input  NUM_PORTS*8  per-requester byte; requester k uses bits [8k+7:8k]
i_req_last  input  NUM_PORTS  per-requester end-of-packet
i_req_user  input  NUM_PORTS  per-requester error/abort flag, forwarded unchanged
o_req_ready  output  NUM_PORTS  per-requester ready
o_tx_valid  output  1  to PHY io_tx_valid
o_tx_data  output  8  to PHY io_tx_bits_tdata
o_tx_last  output  1  to PHY io_tx_bits_tlast
o_tx_user  output  1  to PHY io_tx_bits_tuser
i_tx_ready  input  1  from PHY io_tx_ready
o_grant  output  NUM_PORTS  one-hot registered grant; all zero when no packet is owned
o_busy  output  1  high in XFER or GAP

Behaviour:
- Clocking: single clock i_clock. Reset i_reset is asynchronous and active-high. All state is cleared on assertion; release is synchronous to i_clock.
- Reset values: state=IDLE, o_grant=0, rr pointer=0, gap counter=0, o_busy=0. Consequently o_tx_valid=0, o_tx_data=0, o_tx_last=0, o_tx_user=0 and o_req_ready=0.
- States: IDLE, XFER, GAP.
- IDLE:
  - If any i_req_valid bit is set, select the first set index scanning from the rr pointer upward, wrapping modulo NUM_PORTS.
  - Register the selection into o_grant and go to XFER. Arbitration latency is exactly 1 cycle.
  - No beat is transferred in IDLE.
- XFER, datapath combinational with zero added latency, granted index g:
  - o_tx_valid = i_req_valid[g]; o_tx_data/last/user = requester g fields.
  - o_req_ready[g] = i_tx_ready; all other o_req_ready bits = 0.
  - Non-granted requesters are stalled, never dropped.
  - Beat accepted when o_tx_valid && i_tx_ready.
- End of packet: on an accepted beat with i_req_last[g]=1:
  - rr pointer <= (g+1) mod NUM_PORTS.
  - o_grant <= 0.
  - Next state is GAP with counter=GAP_CYCLES if GAP_CYCLES>0, else IDLE.
- GAP: counter decrements each cycle; all outputs are idle; go to IDLE when counter reaches 1. Total idle = GAP_CYCLES cycles, plus the 1-cycle arbitration in IDLE.
- Grant hold: the grant stays with g if i_req_valid[g] drops mid-packet. o_tx_valid drops with it and no timeout applies.
- Single-beat packet (valid and last on the first beat): legal, handled as above.
- i_tx_ready low: no beat is accepted and no state changes.
- Simultaneous requests: exactly one grant per packet; the rr order guarantees each active requester is served within NUM_PORTS packets.
- A requester whose valid rises in the same cycle another's packet ends waits for the next IDLE arbitration.
- Reset mid-packet: the packet is truncated; the PHY sees o_tx_valid fall without tlast. Recovery is the PHY's responsibility.
- tuser is passed through unchanged and does not alter arbitration.

Test Plan:
- Reset/idle: assert i_reset asynchronously mid-cycle -> all outputs 0 immediately. Release with no requests -> state stays IDLE, o_grant=0.
- Single requester: port 2 sends a 5-byte packet 0x11..0x15 with i_tx_ready=1 -> o_grant=4'b0100 one cycle after valid. PHY sees 0x11..0x15 on consecutive cycles with last on 0x15. o_grant=0 the following cycle.
- Round-robin fairness: all 4 ports continuously send 3-byte packets -> grant order 0,1,2,3,0,1…. No interleaving inside any packet.
- Backpressure: toggle i_tx_ready 1,0,1,0 during a 4-byte packet -> every byte appears exactly once, in order. o_req_ready[g] mirrors i_tx_ready; other ready bits stay 0.
- Gap: GAP_CYCLES=3, ports 0 and 1 both pending -> exactly 3 GAP cycles plus 1 IDLE cycle between port 0's last beat and port 1's first beat. o_busy is high during GAP.
- Mid-packet stall and tuser: port 3 drops valid for 2 cycles mid-packet while port 0 is requesting -> grant stays on port 3. A last beat with i_req_user=1 appears on o_tx_user=1.
